// File: rtl/spi_display_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_display_pkg: job codes, pin bundle and ILI-style panel constants.
// Rev 1.0
// ----------------------------------------------------------------------------
package spi_display_pkg;

  typedef enum logic [1:0] {
    JOB_NONE  = 2'd0,
    JOB_INIT  = 2'd1,
    JOB_CLEAR = 2'd2,
    JOB_DRAW  = 2'd3
  } job_e;

  localparam int WIDTH  = 240;
  localparam int HEIGHT = 320;

  localparam logic [7:0] SWRESET    = 8'h01;
  localparam logic [7:0] SET_COLUMN = 8'h2A;
  localparam logic [7:0] SET_PAGE   = 8'h2B;
  localparam logic [7:0] WRITE_RAM  = 8'h2C;

  typedef struct packed {
    logic cs;
    logic dc;
    logic mosi;
  } pins_t;

  localparam pins_t PINS_IDLE = '{cs: 1'b1, dc: 1'b0, mosi: 1'b0};

endpackage
`default_nettype wire

// File: rtl/spi_display_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_display_sequencer_if: requests, engine handshakes, engine pins and panel pins.
// Rev 1.0
// ----------------------------------------------------------------------------
interface spi_display_sequencer_if;

  logic       i_req_clear;
  logic       i_req_draw;
  logic       o_start_init;
  logic       o_start_clear;
  logic       o_start_draw;
  logic       i_done_init;
  logic       i_done_clear;
  logic       i_done_draw;
  logic       i_mosi_init;
  logic       i_dc_init;
  logic       i_cs_init;
  logic       i_mosi_clear;
  logic       i_dc_clear;
  logic       i_cs_clear;
  logic       i_mosi_draw;
  logic       i_dc_draw;
  logic       i_cs_draw;
  logic       o_mosi;
  logic       o_dc;
  logic       o_cs;
  logic [1:0] o_job;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic       o_sub_rst;

  // Sequencer side
  modport slave (
    input  i_req_clear, i_req_draw,
    input  i_done_init, i_done_clear, i_done_draw,
    input  i_mosi_init, i_dc_init, i_cs_init,
    input  i_mosi_clear, i_dc_clear, i_cs_clear,
    input  i_mosi_draw, i_dc_draw, i_cs_draw,
    output o_start_init, o_start_clear, o_start_draw,
    output o_mosi, o_dc, o_cs,
    output o_job, o_busy, o_done, o_err, o_sub_rst
  );

  // Engines / requester side
  modport master (
    output i_req_clear, i_req_draw,
    output i_done_init, i_done_clear, i_done_draw,
    output i_mosi_init, i_dc_init, i_cs_init,
    output i_mosi_clear, i_dc_clear, i_cs_clear,
    output i_mosi_draw, i_dc_draw, i_cs_draw,
    input  o_start_init, o_start_clear, o_start_draw,
    input  o_mosi, o_dc, o_cs,
    input  o_job, o_busy, o_done, o_err, o_sub_rst
  );

endinterface
`default_nettype wire

// File: rtl/spi_display_sequencer_watchdog.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_job_watchdog: saturating run-time counter, expire pulse at TIMEOUT-1.
// Rev 1.0
// ----------------------------------------------------------------------------
module spi_job_watchdog #(
  parameter int TIMEOUT = 50_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      cnt_q <= '0;
    end else if (i_en && (cnt_q != CNT_LAST)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign o_expire = i_en && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/spi_display_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_display_sequencer: queues init/clear/draw jobs, grants one engine at a time.
// Rev 1.0
// ----------------------------------------------------------------------------
module spi_display_sequencer
  import spi_display_pkg::*;
#(
  parameter int TIMEOUT    = 50_000_000,
  parameter int GAP_CYCLES = 2,
  parameter int AUTO_INIT  = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  spi_display_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_e           state_q;
  job_e             job_q;
  job_e             grant_job;
  logic [GAP_W-1:0] gap_q;
  logic             pend_init_q, pend_clear_q, pend_draw_q;
  logic             pend_init_d, pend_clear_d, pend_draw_d;
  logic             init_ok_q;
  logic             start_init_q, start_clear_q, start_draw_q;
  logic             done_q, err_q, sub_rst_q;
  logic             job_done;
  logic             wd_expire;
  logic             abort;
  pins_t            pins;

  // Clear/draw wait for a completed init; init always wins.
  always_comb begin
    grant_job = JOB_NONE;
    if (state_q == ST_IDLE) begin
      if (pend_init_q)                    grant_job = JOB_INIT;
      else if (init_ok_q && pend_clear_q) grant_job = JOB_CLEAR;
      else if (init_ok_q && pend_draw_q)  grant_job = JOB_DRAW;
    end
  end

  always_comb begin
    job_done = 1'b0;
    pins     = PINS_IDLE;
    case (job_q)
      JOB_INIT: begin
        job_done = bus.i_done_init;
        pins     = '{cs: bus.i_cs_init, dc: bus.i_dc_init, mosi: bus.i_mosi_init};
      end
      JOB_CLEAR: begin
        job_done = bus.i_done_clear;
        pins     = '{cs: bus.i_cs_clear, dc: bus.i_dc_clear, mosi: bus.i_mosi_clear};
      end
      JOB_DRAW: begin
        job_done = bus.i_done_draw;
        pins     = '{cs: bus.i_cs_draw, dc: bus.i_dc_draw, mosi: bus.i_mosi_draw};
      end
      default: begin
        job_done = 1'b0;
        pins     = PINS_IDLE;
      end
    endcase
  end

  assign abort = (state_q == ST_RUN) && !job_done && wd_expire;

  // A request on the grant edge keeps the flag set so the job reruns.
  assign pend_init_d  = (pend_init_q && (grant_job != JOB_INIT)) || (abort && (job_q == JOB_INIT));
  assign pend_clear_d = (pend_clear_q && (grant_job != JOB_CLEAR)) || bus.i_req_clear;
  assign pend_draw_d  = (pend_draw_q && (grant_job != JOB_DRAW)) || bus.i_req_draw;

  spi_job_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (grant_job != JOB_NONE),
    .i_en     (state_q == ST_RUN),
    .o_expire (wd_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      job_q         <= JOB_NONE;
      gap_q         <= '0;
      pend_init_q   <= (AUTO_INIT != 0);
      pend_clear_q  <= 1'b0;
      pend_draw_q   <= 1'b0;
      init_ok_q     <= 1'b0;
      start_init_q  <= 1'b0;
      start_clear_q <= 1'b0;
      start_draw_q  <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      sub_rst_q     <= 1'b0;
    end else begin
      pend_init_q  <= pend_init_d;
      pend_clear_q <= pend_clear_d;
      pend_draw_q  <= pend_draw_d;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      sub_rst_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_job != JOB_NONE) begin
            job_q         <= grant_job;
            start_init_q  <= (grant_job == JOB_INIT);
            start_clear_q <= (grant_job == JOB_CLEAR);
            start_draw_q  <= (grant_job == JOB_DRAW);
            state_q       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (job_done || wd_expire) begin
            job_q         <= JOB_NONE;
            start_init_q  <= 1'b0;
            start_clear_q <= 1'b0;
            start_draw_q  <= 1'b0;
            gap_q         <= GAP_LAST;
            state_q       <= ST_GAP;
            if (job_done) begin
              done_q <= 1'b1;
              if (job_q == JOB_INIT) init_ok_q <= 1'b1;
            end else begin
              err_q     <= 1'b1;
              sub_rst_q <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (gap_q == '0) state_q <= ST_IDLE;
          else             gap_q   <= gap_q - GAP_W'(1);
        end
        default: begin
          state_q <= ST_IDLE;
          job_q   <= JOB_NONE;
        end
      endcase
    end
  end

  assign bus.o_start_init  = start_init_q;
  assign bus.o_start_clear = start_clear_q;
  assign bus.o_start_draw  = start_draw_q;
  assign bus.o_job         = job_q;
  assign bus.o_busy        = (state_q != ST_IDLE);
  assign bus.o_done        = done_q;
  assign bus.o_err         = err_q;
  assign bus.o_sub_rst     = sub_rst_q;
  assign bus.o_cs          = pins.cs;
  assign bus.o_dc          = pins.dc;
  assign bus.o_mosi        = pins.mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_display_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_spi_display_sequencer: vector table, corner sequences and random traffic vs a job-level model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_spi_display_sequencer;

  localparam int TIMEOUT = 120;
  localparam int GAP     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_display_sequencer_if bus();

  spi_display_sequencer #(
    .TIMEOUT    (TIMEOUT),
    .GAP_CYCLES (GAP),
    .AUTO_INIT  (1)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int n_odone = 0;

  // Job-level reference: active job, its age, remaining gap edges, pending set.
  int       m_job  = 0;
  int       m_age  = 0;
  int       m_hold = 0;
  bit [3:0] m_pend = 4'b0010;
  bit       m_ok   = 1'b0;
  bit       m_done = 1'b0;
  bit       m_err  = 1'b0;

  typedef struct {
    bit       rst;
    bit       rq_c;
    bit       rq_d;
    bit [2:0] dn;    // {draw, clear, init}
    bit [1:0] job;
    bit       busy;
    bit       done;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_edge();
    bit [3:0] dn;
    dn     = {bus.i_done_draw, bus.i_done_clear, bus.i_done_init, 1'b0};
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      m_job  = 0;
      m_age  = 0;
      m_hold = 0;
      m_pend = 4'b0010;
      m_ok   = 1'b0;
    end else begin
      if (m_job != 0) begin
        if (dn[m_job]) begin
          m_done = 1'b1;
          if (m_job == 1) m_ok = 1'b1;
          m_job  = 0;
          m_hold = GAP;
        end else if (m_age == TIMEOUT - 1) begin
          m_err = 1'b1;
          if (m_job == 1) m_pend[1] = 1'b1;
          m_job  = 0;
          m_hold = GAP;
        end else begin
          m_age++;
        end
      end else if (m_hold > 0) begin
        m_hold--;
      end else begin
        for (int k = 1; k <= 3; k++) begin
          if (m_job == 0 && m_pend[k] && (k == 1 || m_ok)) begin
            m_job     = k;
            m_age     = 0;
            m_pend[k] = 1'b0;
          end
        end
      end
      if (bus.i_req_clear) m_pend[2] = 1'b1;
      if (bus.i_req_draw)  m_pend[3] = 1'b1;
    end
  endtask

  function automatic logic [11:0] act_vec();
    return {bus.o_job, bus.o_start_init, bus.o_start_clear, bus.o_start_draw, bus.o_busy,
            bus.o_done, bus.o_err, bus.o_sub_rst, bus.o_cs, bus.o_dc, bus.o_mosi};
  endfunction

  function automatic logic [11:0] exp_vec();
    logic [2:0] p;
    case (m_job)
      1:       p = {bus.i_cs_init, bus.i_dc_init, bus.i_mosi_init};
      2:       p = {bus.i_cs_clear, bus.i_dc_clear, bus.i_mosi_clear};
      3:       p = {bus.i_cs_draw, bus.i_dc_draw, bus.i_mosi_draw};
      default: p = 3'b100;
    endcase
    return {2'(m_job), m_job == 1, m_job == 2, m_job == 3, (m_job != 0 || m_hold != 0),
            m_done, m_err, m_err, p};
  endfunction

  task automatic step(input bit cmp, input string name);
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    if (bus.o_done === 1'b1) n_odone++;
    if (cmp) check(name, 32'(act_vec()), 32'(exp_vec()));
    bus.i_req_clear  = 1'b0;
    bus.i_req_draw   = 1'b0;
    bus.i_done_init  = 1'b0;
    bus.i_done_clear = 1'b0;
    bus.i_done_draw  = 1'b0;
    {bus.i_cs_init,  bus.i_dc_init,  bus.i_mosi_init}  = 3'($urandom);
    {bus.i_cs_clear, bus.i_dc_clear, bus.i_mosi_clear} = 3'($urandom);
    {bus.i_cs_draw,  bus.i_dc_draw,  bus.i_mosi_draw}  = 3'($urandom);
  endtask

  task automatic wait_job(input logic [1:0] code, input string name, output int t);
    int n = 0;
    while (bus.o_job !== code && n < 200) begin
      step(1'b1, name);
      n++;
    end
    check({name, "_grant"}, 32'(bus.o_job), 32'(code));
    t = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0, t1, td;
    bit seen_err;

    tbl[0]  = '{1, 0, 0, 3'b000, 2'd0, 0, 0};
    tbl[1]  = '{0, 0, 0, 3'b000, 2'd1, 1, 0};
    tbl[2]  = '{0, 0, 0, 3'b000, 2'd1, 1, 0};
    tbl[3]  = '{0, 0, 1, 3'b000, 2'd1, 1, 0};
    tbl[4]  = '{0, 0, 0, 3'b001, 2'd0, 1, 1};
    tbl[5]  = '{0, 0, 0, 3'b000, 2'd0, 1, 0};
    tbl[6]  = '{0, 0, 0, 3'b000, 2'd0, 0, 0};
    tbl[7]  = '{0, 0, 0, 3'b000, 2'd3, 1, 0};
    tbl[8]  = '{0, 0, 1, 3'b100, 2'd0, 1, 1};
    tbl[9]  = '{0, 0, 0, 3'b000, 2'd0, 1, 0};
    tbl[10] = '{0, 0, 0, 3'b000, 2'd0, 0, 0};
    tbl[11] = '{0, 0, 0, 3'b000, 2'd3, 1, 0};
    tbl[12] = '{0, 0, 0, 3'b010, 2'd3, 1, 0};
    tbl[13] = '{0, 0, 0, 3'b100, 2'd0, 1, 1};

    rst              = 1'b1;
    bus.i_req_clear  = 1'b0;
    bus.i_req_draw   = 1'b0;
    bus.i_done_init  = 1'b0;
    bus.i_done_clear = 1'b0;
    bus.i_done_draw  = 1'b0;
    {bus.i_cs_init,  bus.i_dc_init,  bus.i_mosi_init}  = 3'b010;
    {bus.i_cs_clear, bus.i_dc_clear, bus.i_mosi_clear} = 3'b001;
    {bus.i_cs_draw,  bus.i_dc_draw,  bus.i_mosi_draw}  = 3'b011;
    step(1'b0, "");
    step(1'b1, "reset_state");

    for (int i = 0; i < 14; i++) begin
      rst              = tbl[i].rst;
      bus.i_req_clear  = tbl[i].rq_c;
      bus.i_req_draw   = tbl[i].rq_d;
      bus.i_done_init  = tbl[i].dn[0];
      bus.i_done_clear = tbl[i].dn[1];
      bus.i_done_draw  = tbl[i].dn[2];
      step(1'b0, "");
      check($sformatf("table[%0d]", i),
            32'({bus.o_job, bus.o_start_init, bus.o_start_clear, bus.o_start_draw,
                 bus.o_busy, bus.o_done}),
            32'({tbl[i].job, tbl[i].job == 2'd1, tbl[i].job == 2'd2, tbl[i].job == 2'd3,
                 tbl[i].busy, tbl[i].done}));
    end
    rst = 1'b0;

    // Simultaneous clear + draw: clear first, draw GAP+1 edges after clear's done.
    n_odone         = 0;
    bus.i_req_clear = 1'b1;
    bus.i_req_draw  = 1'b1;
    step(1'b1, "dual_req");
    wait_job(2'd2, "dual_clear", t0);
    repeat (5) step(1'b1, "dual_run");
    bus.i_done_clear = 1'b1;
    step(1'b1, "dual_run");
    td = cyc;
    wait_job(2'd3, "dual_draw", t1);
    check("draw_after_clear_gap", 32'(t1 - td), 32'(GAP + 1));
    repeat (3) step(1'b1, "dual_run");
    bus.i_done_draw = 1'b1;
    step(1'b1, "dual_run");
    repeat (GAP + 4) step(1'b1, "dual_tail");
    check("dual_done_pulses", 32'(n_odone), 32'd2);

    // Hung clear: abort after TIMEOUT cycles of start, stray draw done ignored.
    n_odone         = 0;
    seen_err        = 1'b0;
    bus.i_req_clear = 1'b1;
    step(1'b1, "hang_req");
    wait_job(2'd2, "hang_clear", t0);
    t1 = t0;
    for (int i = 0; i < TIMEOUT + 10 && !seen_err; i++) begin
      if (i == 7) bus.i_done_draw = 1'b1;
      step(1'b1, "hang_run");
      if (bus.o_err === 1'b1) begin
        seen_err = 1'b1;
        t1       = cyc;
      end
    end
    check("hang_err_seen", 32'(seen_err), 32'd1);
    check("hang_run_length", 32'(t1 - t0), 32'(TIMEOUT));
    repeat (GAP + 4) step(1'b1, "hang_tail");
    check("hang_no_done", 32'(n_odone), 32'd0);
    check("hang_idle", 32'({bus.o_busy, bus.o_job}), 32'd0);

    // Reset in the middle of a clear job, with a draw pending.
    bus.i_req_clear = 1'b1;
    step(1'b1, "midrst_req");
    wait_job(2'd2, "midrst_clear", t0);
    repeat (4) step(1'b1, "midrst_run");
    bus.i_req_draw = 1'b1;
    step(1'b1, "midrst_run");
    rst = 1'b1;
    step(1'b1, "midrst_reset");
    check("midrst_pins",
          32'({bus.o_start_init, bus.o_start_clear, bus.o_start_draw, bus.o_cs, bus.o_job}),
          32'b0001_00);
    rst = 1'b0;
    wait_job(2'd1, "midrst_init", t0);
    repeat (3) step(1'b1, "midrst_init_run");
    bus.i_done_init = 1'b1;
    step(1'b1, "midrst_init_run");
    repeat (GAP + 6) step(1'b1, "midrst_tail");
    check("midrst_no_requeue", 32'(bus.o_job), 32'd0);

    // Random traffic, stray dones, aborts and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      bus.i_req_clear  = ($urandom_range(0, 11) == 0);
      bus.i_req_draw   = ($urandom_range(0, 11) == 0);
      bus.i_done_init  = ($urandom_range(0, (m_job == 1) ? 29 : 59) == 0);
      bus.i_done_clear = ($urandom_range(0, (m_job == 2) ? 29 : 59) == 0);
      bus.i_done_draw  = ($urandom_range(0, (m_job == 3) ? 29 : 59) == 0);
      rst              = ($urandom_range(0, 999) == 0);
      step(1'b1, "random");
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
